// File: rtl/alu_ctl_pkg.sv
// Shared constants for the EX-stage ALU control and mul/div engine:
// ALU control codes, funct values, ALUOp encodings, FSM state and engine op types.
package alu_ctl_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding equals funct[1:0] of the four engine instructions.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_ctl_muldiv_if.sv
// EX-stage bus between the pipeline (master) and the ALU control / mul-div block (slave).
interface alu_ctl_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
);
  // op_valid qualifies the instruction fields every cycle; stall acts as the
  // inverted ready: an engine op or HI/LO read completes on an edge with
  // op_valid=1 and stall=0, and the master holds all fields while stall=1.
  logic [1:0]       alu_op;
  logic [5:0]       func_code;
  logic             op_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  logic [CTL_W-1:0] alu_ctl;
  logic             illegal;
  logic             hilo_rd;
  logic [WIDTH-1:0] hilo_rdata;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       state;

  modport master (
    output alu_op, func_code, op_valid, src_a, src_b,
    input  alu_ctl, illegal, hilo_rd, hilo_rdata, stall, busy, done, hi, lo, state
  );

  modport slave (
    input  alu_op, func_code, op_valid, src_a, src_b,
    output alu_ctl, illegal, hilo_rd, hilo_rdata, stall, busy, done, hi, lo, state
  );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per cycle
// on magnitudes, with the sign fix-up applied to the result of the final step.
module muldiv_iter
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CNT_W = $clog2(WIDTH);

  logic                 running;
  logic [CNT_W-1:0]     count;
  md_op_e               op_q;
  logic                 neg_lo;
  logic                 neg_hi;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 sgn;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  assign sgn   = md_is_signed(op);
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc = {partial product, multiplier} for mul, {remainder, quotient} for div.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd};
    acc_nxt = acc;
    if (md_is_div(op_q)) begin
      if (!diff[WIDTH]) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

  assign prod = neg_lo ? -acc_nxt : acc_nxt;

  always_comb begin
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (md_is_div(op_q)) begin
      hi_res = neg_hi ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
      lo_res = neg_lo ? -acc_nxt[WIDTH-1:0]       : acc_nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      op_q    <= MD_MULT;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= CNT_W'(WIDTH - 1);
      op_q    <= op;
      neg_lo  <= a_neg ^ b_neg;
      if (md_is_div(op)) begin
        neg_hi <= a_neg;
        opnd   <= b_mag;
        acc    <= {{WIDTH{1'b0}}, a_mag};
      end else begin
        neg_hi <= a_neg ^ b_neg;
        opnd   <= a_mag;
        acc    <= {{WIDTH{1'b0}}, b_mag};
      end
    end else if (running) begin
      acc   <= acc_nxt;
      count <= count - 1'b1;
      if (count == '0) running <= 1'b0;
    end
  end

  assign busy = running;
  assign done = running && (count == '0);

endmodule

// File: rtl/alu_ctl_muldiv.sv
// EX-stage ALU control decode plus the mul/div sequencer, HI/LO registers and
// the stall that holds the pipeline while the engine is iterating.
module alu_ctl_muldiv
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctl_muldiv_if.slave bus
);

  state_e           state;
  logic [CTL_W-1:0] ctl;
  logic             illegal;
  logic             is_md;
  logic             hilo_rd;
  logic             rd_hi;
  logic             accept;
  logic             div_zero;
  logic             iter_start;
  logic             iter_busy;
  logic             iter_done;
  md_op_e           md_op;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;

  assign md_op = md_op_e'(bus.func_code[1:0]);

  always_comb begin
    ctl     = CTL_W'(CTL_AND);
    illegal = 1'b0;
    is_md   = 1'b0;
    hilo_rd = 1'b0;
    rd_hi   = 1'b0;
    case (bus.alu_op)
      ALUOP_ADD: ctl = CTL_W'(CTL_ADD);
      ALUOP_SUB: ctl = CTL_W'(CTL_SUB);
      ALUOP_RTYPE: begin
        case (bus.func_code)
          FN_ADD: ctl = CTL_W'(CTL_ADD);
          FN_SUB: ctl = CTL_W'(CTL_SUB);
          FN_AND: ctl = CTL_W'(CTL_AND);
          FN_OR:  ctl = CTL_W'(CTL_OR);
          FN_SLT: ctl = CTL_W'(CTL_SLT);
          FN_NOR: ctl = CTL_W'(CTL_NOR);
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_md = 1'b1;
          FN_MFHI: begin
            hilo_rd = 1'b1;
            rd_hi   = 1'b1;
          end
          FN_MFLO: hilo_rd = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // A new engine op may start from IDLE or straight out of DONE.
  assign div_zero   = md_is_div(md_op) && (bus.src_b == '0);
  assign accept     = bus.op_valid && is_md && (state != ST_RUN);
  assign iter_start = accept && !div_zero;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .op     (md_op),
    .a      (bus.src_a),
    .b      (bus.src_b),
    .busy   (iter_busy),
    .done   (iter_done),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (iter_done) begin
            state <= ST_DONE;
            hi_q  <= hi_res;
            lo_q  <= lo_res;
          end
        end
        default: begin
          if (accept && div_zero) begin
            state <= ST_DONE;
            hi_q  <= bus.src_a;
            lo_q  <= '1;
          end else if (accept) begin
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.alu_ctl    = ctl;
  assign bus.illegal    = illegal;
  assign bus.hilo_rd    = hilo_rd;
  assign bus.hilo_rdata = hilo_rd ? (rd_hi ? hi_q : lo_q) : '0;
  assign bus.busy       = iter_busy;
  assign bus.done       = (state == ST_DONE);
  assign bus.stall      = bus.op_valid && iter_busy && (is_md || hilo_rd);
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_alu_ctl_muldiv.sv
// Bench for alu_ctl_muldiv: decode vector table, hand-written mul/div sequences,
// and random engine ops checked through an expected-result queue.
module tb_alu_ctl_muldiv;

  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_SLT   = 6'b101010;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [2*W-1:0] exp_q[$];

  alu_ctl_muldiv_if #(.WIDTH(W), .CTL_W(4)) bus ();

  alu_ctl_muldiv #(.WIDTH(W), .CTL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctl;
    logic       ill;
    logic       hrd;
  } dec_vec_t;

  dec_vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected {hi,lo}.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done act=%h_%h exp=no_done", bus.hi, bus.lo);
      end else begin
        check("sb_hilo", {bus.hi, bus.lo}, exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.op_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.func_code = 6'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
  endtask

  task automatic drive_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_valid  = 1'b1;
    bus.alu_op    = 2'b10;
    bus.func_code = fn;
    bus.src_a     = a;
    bus.src_b     = b;
  endtask

  function automatic logic [2*W-1:0] md_model(input logic [5:0] fn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (fn)
      F_MULT:  return sa * sb;
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_hilo, input string name);
    int   n;
    int   lat;
    logic got;
    logic bad_busy;
    lat = (fn[1] && b == '0) ? 1 : W + 1;
    @(posedge clk); #1;
    drive_op(fn, a, b);
    exp_q.push_back(exp_hilo);
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    got = 1'b0;
    bad_busy = 1'b0;
    while (!got && n < 3 * W) begin
      @(negedge clk);
      n++;
      if (bus.busy !== (n < lat)) bad_busy = 1'b1;
      if (bus.done === 1'b1) got = 1'b1;
    end
    check({name, "_done_cycle"}, n, lat);
    check({name, "_busy"}, bad_busy, 1'b0);
  endtask

  initial begin
    logic bad;
    int   n;
    int   dones;
    logic [5:0] fn;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 6'b100000, 4'b0110, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 6'b011000, 4'b0000, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 6'b011011, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 6'b010000, 4'b0000, 1'b0, 1'b1};
    vecs[11] = '{2'b10, 6'b010010, 4'b0000, 1'b0, 1'b1};
    vecs[12] = '{2'b10, 6'b111111, 4'b0000, 1'b1, 1'b0};
    vecs[13] = '{2'b11, 6'b100000, 4'b0000, 1'b1, 1'b0};

    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_state", bus.state, 2'd0);

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      bus.alu_op    = vecs[i].op;
      bus.func_code = vecs[i].fn;
      bus.op_valid  = (vecs[i].fn == F_SLT);
      @(negedge clk);
      check($sformatf("dec%0d_ctl", i), bus.alu_ctl, vecs[i].ctl);
      check($sformatf("dec%0d_illegal", i), bus.illegal, vecs[i].ill);
      check($sformatf("dec%0d_hilo_rd", i), bus.hilo_rd, vecs[i].hrd);
      check($sformatf("dec%0d_stall", i), bus.stall, 1'b0);
    end
    @(posedge clk); #1;
    idle_inputs();

    run_md(F_MULT,  32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, "mult");
    run_md(F_MULTU, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB}, "multu");
    run_md(F_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
    run_md(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_min");
    run_md(F_DIVU,  32'd7, 32'd0, {32'h0000_0007, 32'hFFFF_FFFF}, "divu_zero");
    run_md(F_DIV,   32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF}, "div_zero");

    @(posedge clk); #1;
    drive_op(F_MFHI, '0, '0);
    @(negedge clk);
    check("mfhi_rdata", bus.hilo_rdata, 32'h5);
    check("mfhi_stall", bus.stall, 1'b0);

    // DIVU 100/7 with an SLT then an MFLO issued while the engine iterates.
    @(posedge clk); #1;
    drive_op(F_DIVU, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    @(posedge clk); #1;
    drive_op(F_SLT, '0, '0);
    bad = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        if (bus.stall !== (c <= W)) bad = 1'b1;
      end else begin
        if (bus.stall !== 1'b0) bad = 1'b1;
      end
      if (c == W + 1) begin
        check("mflo_held_rdata", bus.hilo_rdata, 32'h0000_000E);
        check("mflo_held_done", bus.done, 1'b1);
      end
      if (c == 4) begin
        @(posedge clk); #1;
        bus.func_code = F_MFLO;
      end
    end
    check("mflo_stall_pattern", bad, 1'b0);
    @(posedge clk); #1;
    idle_inputs();

    // Second engine op held while busy, then taken straight out of DONE.
    @(posedge clk); #1;
    drive_op(F_MULT, 32'd3, 32'd5);
    exp_q.push_back({32'd0, 32'd15});
    @(posedge clk); #1;
    drive_op(F_DIVU, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    n = 0;
    dones = 0;
    bad = 1'b0;
    while (dones < 2 && n < 4 * W) begin
      @(negedge clk);
      n++;
      if (n <= W && bus.stall !== 1'b1) bad = 1'b1;
      if (bus.done === 1'b1) begin
        if (bus.stall !== 1'b0) bad = 1'b1;
        dones++;
        if (dones == 1) begin
          check("b2b_first_done", n, W + 1);
          @(posedge clk); #1;
          idle_inputs();
        end else begin
          check("b2b_second_done", n, 2 * W + 2);
        end
      end
    end
    check("b2b_done_count", dones, 2);
    check("b2b_stall", bad, 1'b0);

    // Reset in the middle of a MULT aborts it with no done pulse.
    @(posedge clk); #1;
    drive_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    @(posedge clk); #1;
    idle_inputs();
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);
    check("abort_done", bus.done, 1'b0);
    check("abort_state", bus.state, 2'd0);
    repeat (W + 8) @(negedge clk);
    run_md(F_MULTU, 32'd3, 32'd4, {32'd0, 32'h0000_000C}, "multu_after_abort");

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: fn = F_MULT;
        1: fn = F_MULTU;
        2: fn = F_DIV;
        default: fn = F_DIVU;
      endcase
      ra = $urandom;
      rb = (k % 3 == 2) ? W'($urandom_range(0, 20)) : $urandom;
      if (k == 5) ra = 32'h8000_0000;
      run_md(fn, ra, rb, md_model(fn, ra, rb), $sformatf("rand%0d", k));
    end

    repeat (3) @(negedge clk);
    check("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
